dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 REFRESH_INTERVAL, 312, clocks between refresh ticks (15.6 us at 20 MHz CLK).
REQ-002 MAX_PENDING, 4, refresh backlog limit; PW = $clog2(MAX_PENDING+1).
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 CS  input  1  active-low DRAM chip select from address decoder.
REQ-006 AS  input  1  active-low 68000 address strobe.
REQ-007 DMA_REQ  input  1  active-high DMA requester access request.
REQ-008 DONE  input  1  one-cycle pulse from DRAM sequencer: granted cycle complete.
REQ-009 START  output  1  one-cycle pulse: sequencer begins cycle of type SEL.
REQ-010 SEL  output  2  current owner: 00 none, 01 CPU, 10 DMA, 11 refresh.
REQ-011 DMA_ACK  output  1  one-cycle pulse: DMA transfer finished.
REQ-012 REF_PENDING  output  PW  outstanding refresh count.
REQ-013 REF_OVERRUN  output  1  sticky flag: refresh tick lost at full backlog.

Function
REQ-014 Refresh timer SHALL count 0..REFRESH_INTERVAL-1 free-running, wrapping to 0 and asserting an internal tick on the wrap edge.
REQ-015 Tick SHALL increment REF_PENDING; DONE in REF_CYC SHALL decrement it; both in same cycle SHALL leave it unchanged.
REQ-016 Tick with REF_PENDING == MAX_PENDING and no simultaneous refresh DONE SHALL hold the count and set REF_OVERRUN until reset.
REQ-017 CPU request SHALL be CS == 0 and AS == 0 sampled at the rising edge.
REQ-018 State machine SHALL have states IDLE, CPU_CYC, DMA_CYC, REF_CYC, CPU_HOLD.
REQ-019 In IDLE, priority SHALL be: urgent refresh (REF_PENDING >= MAX_PENDING-1), then CPU/DMA, then non-urgent refresh (REF_PENDING > 0, no CPU/DMA request).
REQ-020 CPU and DMA both requesting SHALL resolve round-robin: requester not served last wins; last-owner flag updated on every CPU/DMA grant.
REQ-021 Grant SHALL move IDLE to the cycle state on the sampling edge; START SHALL be high exactly during the first cycle in that state (one-cycle latency).
REQ-022 SEL SHALL be set with START and stay stable until the edge at which DONE is sampled; SEL SHALL be 00 in IDLE and CPU_HOLD.
REQ-023 DONE in CPU_CYC SHALL go to CPU_HOLD if AS == 0, else IDLE; CPU_HOLD SHALL go to IDLE on AS == 1 (one DRAM access per bus cycle).
REQ-024 AS rising before DONE in CPU_CYC SHALL NOT abort; arbiter waits for DONE.
REQ-025 DONE in DMA_CYC SHALL go to IDLE and pulse DMA_ACK in the following cycle.
REQ-026 DONE in REF_CYC SHALL go to IDLE.
REQ-027 DONE in IDLE or CPU_HOLD SHALL be ignored.
REQ-028 Back-to-back grants SHALL be separated by at least one IDLE cycle.

Reset
REQ-029 RST high SHALL immediately force IDLE, START=0, SEL=00, DMA_ACK=0, REF_PENDING=0, REF_OVERRUN=0, timer=0, last-owner=DMA.
REQ-030 Reset mid-cycle SHALL discard the grant; first post-reset grant follows REQ-019 normally.

Structure
REQ-031 Shared package SHALL hold SEL encodings (SEL_NONE/CPU/DMA/REF) and state enum, reused by the DRAM sequencer.
REQ-032 Refresh timer plus pending counter SHALL be one sub-module, dram_refresh_timer, exposing tick, REF_PENDING, REF_OVERRUN and a decrement input.

Verification
REQ-033 RST pulsed during CPU_CYC -> same-cycle SEL=00, START=0, REF_PENDING=0; no START until request re-sampled.
REQ-034 CS=0, AS=0 at edge N -> START=1 and SEL=01 in cycle N+1 only; DONE at N+5 -> SEL=00, no second START while AS held low; AS=1 -> IDLE.
REQ-035 No requests for 312 cycles after reset -> REF_PENDING=1, START with SEL=11 next cycle; DONE -> REF_PENDING=0.
REQ-036 CPU and DMA_REQ held continuously from reset -> grants CPU, DMA, CPU, DMA; DMA_ACK one cycle after each DMA DONE.
REQ-037 DONE withheld in DMA_CYC for 1560 cycles -> REF_PENDING=4, REF_OVERRUN=1; after DONE, next grant SEL=11 despite CPU request.
REQ-038 Refresh DONE on same edge as timer tick with REF_PENDING=2 -> REF_PENDING stays 2.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared owner encodings and arbiter state codes for the DRAM arbiter and sequencer.
package dram_arbiter_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_CPU  = 2'b01;
    localparam logic [1:0] SEL_DMA  = 2'b10;
    localparam logic [1:0] SEL_REF  = 2'b11;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 3'd0;
    localparam arb_state_t ST_CPU_CYC  = 3'd1;
    localparam arb_state_t ST_DMA_CYC  = 3'd2;
    localparam arb_state_t ST_REF_CYC  = 3'd3;
    localparam arb_state_t ST_CPU_HOLD = 3'd4;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer with a saturating backlog of owed refreshes.
module dram_refresh_timer
    import dram_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 312,
    parameter int MAX_PENDING      = 4,
    parameter int PW               = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    output logic          tick,
    output logic [PW-1:0] ref_pending,
    output logic          ref_overrun
);

    localparam int TW = $clog2(REFRESH_INTERVAL);

    logic [TW-1:0] timer_q;

    assign tick = (timer_q == TW'(REFRESH_INTERVAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // A tick and a completed refresh on the same edge cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_pending <= '0;
            ref_overrun <= 1'b0;
        end else begin
            case ({tick, dec})
                2'b10: begin
                    if (ref_pending == PW'(MAX_PENDING)) begin
                        ref_overrun <= 1'b1;
                    end else begin
                        ref_pending <= ref_pending + PW'(1);
                    end
                end
                2'b01: begin
                    if (ref_pending != '0) begin
                        ref_pending <= ref_pending - PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the DRAM between the 68000, a DMA requester and refresh, issuing one-cycle START pulses.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 312,
    parameter int MAX_PENDING      = 4,
    parameter int PW               = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          as,
    input  logic          dma_req,
    input  logic          done,
    output logic          start,
    output logic [1:0]    sel,
    output logic          dma_ack,
    output logic [PW-1:0] ref_pending,
    output logic          ref_overrun
);

    arb_state_t state_q;
    logic       last_dma_q;
    logic       cpu_req;
    logic       ref_urgent;
    logic       ref_dec;
    logic       tick_unused;
    logic [1:0] grant_sel;

    assign cpu_req    = ~cs & ~as;
    assign ref_urgent = (ref_pending >= PW'(MAX_PENDING - 1));
    assign ref_dec    = (state_q == ST_REF_CYC) & done;

    dram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PENDING      (MAX_PENDING),
        .PW               (PW)
    ) u_refresh (
        .clk         (clk),
        .rst         (rst),
        .dec         (ref_dec),
        .tick        (tick_unused),
        .ref_pending (ref_pending),
        .ref_overrun (ref_overrun)
    );

    // Urgent refresh beats everyone; CPU/DMA contention alternates on last owner.
    always_comb begin
        grant_sel = SEL_NONE;
        if (ref_urgent) begin
            grant_sel = SEL_REF;
        end else if (cpu_req && (!dma_req || last_dma_q)) begin
            grant_sel = SEL_CPU;
        end else if (dma_req) begin
            grant_sel = SEL_DMA;
        end else if (ref_pending != '0) begin
            grant_sel = SEL_REF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start      <= 1'b0;
            sel        <= SEL_NONE;
            dma_ack    <= 1'b0;
            last_dma_q <= 1'b1;
        end else begin
            start   <= 1'b0;
            dma_ack <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_sel != SEL_NONE) begin
                        start <= 1'b1;
                        sel   <= grant_sel;
                        case (grant_sel)
                            SEL_CPU: begin
                                state_q    <= ST_CPU_CYC;
                                last_dma_q <= 1'b0;
                            end
                            SEL_DMA: begin
                                state_q    <= ST_DMA_CYC;
                                last_dma_q <= 1'b1;
                            end
                            default: state_q <= ST_REF_CYC;
                        endcase
                    end
                end
                ST_CPU_CYC: begin
                    if (done) begin
                        sel     <= SEL_NONE;
                        state_q <= as ? ST_IDLE : ST_CPU_HOLD;
                    end
                end
                // Park until the bus cycle ends so one AS yields one DRAM access.
                ST_CPU_HOLD: begin
                    if (as) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DMA_CYC: begin
                    if (done) begin
                        sel     <= SEL_NONE;
                        dma_ack <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_REF_CYC: begin
                    if (done) begin
                        sel     <= SEL_NONE;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    sel     <= SEL_NONE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed-vector bench for dram_arbiter: CPU hold, round-robin, refresh timing, overrun and reset.
module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          as;
    logic          dma_req;
    logic          done;
    logic          start;
    logic [1:0]    sel;
    logic          dma_ack;
    logic [PW-1:0] ref_pending;
    logic          ref_overrun;

    int vec_cnt = 0;
    int err_cnt = 0;

    dram_arbiter #(
        .REFRESH_INTERVAL (312),
        .MAX_PENDING      (4),
        .PW               (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .as          (as),
        .dma_req     (dma_req),
        .done        (done),
        .start       (start),
        .sel         (sel),
        .dma_ack     (dma_ack),
        .ref_pending (ref_pending),
        .ref_overrun (ref_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        cs      = 1'b1;
        as      = 1'b1;
        dma_req = 1'b0;
        done    = 1'b0;
        cyc(2);
        chk("rst_start", 32'(start), 0);
        chk("rst_sel", 32'(sel), 32'(SEL_NONE));
        chk("rst_ack", 32'(dma_ack), 0);
        chk("rst_pending", 32'(ref_pending), 0);
        chk("rst_overrun", 32'(ref_overrun), 0);
        rst = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [1:0] exp_sel);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            if (start) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, 32'(seen), 1);
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    endtask

    task automatic pulse_done();
        done = 1'b1;
        cyc(1);
        done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs = 1'b1; as = 1'b1; dma_req = 1'b0; done = 1'b0;

        // CPU access, hold until AS rises, no abort on early AS rise
        reset_dut();
        cs = 1'b0; as = 1'b0;
        cyc(1);
        chk("cpu_start", 32'(start), 1);
        chk("cpu_sel", 32'(sel), 32'(SEL_CPU));
        cyc(1);
        chk("cpu_start_once", 32'(start), 0);
        chk("cpu_sel_hold", 32'(sel), 32'(SEL_CPU));
        cyc(2);
        pulse_done();
        chk("cpu_done_sel", 32'(sel), 32'(SEL_NONE));
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("cpu_hold_nostart", 32'(start), 0);
        end
        pulse_done();
        chk("hold_done_ignored", 32'(sel), 32'(SEL_NONE));
        as = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("idle_nostart", 32'(start), 0);
        end
        cs = 1'b0; as = 1'b0;
        wait_start("cpu2", SEL_CPU);
        cs = 1'b1; as = 1'b1;
        cyc(3);
        chk("cpu_no_abort", 32'(sel), 32'(SEL_CPU));
        pulse_done();
        chk("cpu2_done_sel", 32'(sel), 32'(SEL_NONE));
        cyc(1);
        chk("cpu2_idle_nostart", 32'(start), 0);
        pulse_done();
        chk("idle_done_sel", 32'(sel), 32'(SEL_NONE));
        chk("idle_done_pending", 32'(ref_pending), 0);

        // CPU and DMA both requesting alternate, DMA_ACK after each DMA DONE
        reset_dut();
        cs = 1'b0; as = 1'b0; dma_req = 1'b1;
        wait_start("rr1", SEL_CPU);
        pulse_done();
        as = 1'b1;
        cyc(1);
        as = 1'b0;
        wait_start("rr2", SEL_DMA);
        pulse_done();
        chk("rr2_ack", 32'(dma_ack), 1);
        cyc(1);
        chk("rr2_ack_end", 32'(dma_ack), 0);
        chk("rr3_start", 32'(start), 1);
        chk("rr3_sel", 32'(sel), 32'(SEL_CPU));
        pulse_done();
        as = 1'b1;
        cyc(1);
        as = 1'b0;
        wait_start("rr4", SEL_DMA);
        pulse_done();
        chk("rr4_ack", 32'(dma_ack), 1);
        cyc(1);
        chk("rr4_ack_end", 32'(dma_ack), 0);
        dma_req = 1'b0; cs = 1'b1; as = 1'b1;

        // Refresh after 312 idle cycles; DONE coinciding with a tick
        reset_dut();
        cyc(311);
        chk("ref_pend_before", 32'(ref_pending), 0);
        cyc(1);
        chk("ref_pend_tick1", 32'(ref_pending), 1);
        chk("ref_nostart_yet", 32'(start), 0);
        cyc(1);
        chk("ref_start", 32'(start), 1);
        chk("ref_sel", 32'(sel), 32'(SEL_REF));
        cyc(622);
        chk("ref_pend_tick2", 32'(ref_pending), 2);
        chk("ref_sel_held", 32'(sel), 32'(SEL_REF));
        pulse_done();
        chk("ref_tick_and_done", 32'(ref_pending), 2);
        chk("ref_done_sel", 32'(sel), 32'(SEL_NONE));
        wait_start("ref2", SEL_REF);
        pulse_done();
        chk("ref_dec1", 32'(ref_pending), 1);
        wait_start("ref3", SEL_REF);
        pulse_done();
        chk("ref_dec0", 32'(ref_pending), 0);

        // Refresh backlog saturates while DMA withholds DONE
        reset_dut();
        dma_req = 1'b1;
        wait_start("ovr_dma", SEL_DMA);
        cs = 1'b0; as = 1'b0;
        cyc(1600);
        chk("ovr_pending", 32'(ref_pending), 4);
        chk("ovr_flag", 32'(ref_overrun), 1);
        chk("ovr_sel_dma", 32'(sel), 32'(SEL_DMA));
        pulse_done();
        chk("ovr_ack", 32'(dma_ack), 1);
        dma_req = 1'b0;
        wait_start("ovr_urgent", SEL_REF);
        chk("ovr_sticky", 32'(ref_overrun), 1);

        // Asynchronous reset mid-cycle discards the grant immediately
        rst = 1'b1;
        #1;
        chk("arst_start", 32'(start), 0);
        chk("arst_sel", 32'(sel), 32'(SEL_NONE));
        chk("arst_pending", 32'(ref_pending), 0);
        chk("arst_overrun", 32'(ref_overrun), 0);
        cyc(2);
        cs = 1'b1; as = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("post_rst_nostart", 32'(start), 0);
        end
        cs = 1'b0; as = 1'b0;
        cyc(1);
        chk("post_rst_start", 32'(start), 1);
        chk("post_rst_sel", 32'(sel), 32'(SEL_CPU));
        rst = 1'b1;
        #1;
        chk("cpu_arst_start", 32'(start), 0);
        chk("cpu_arst_sel", 32'(sel), 32'(SEL_NONE));
        cyc(1);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
